dds_phase_gen: RTL and testbench
================================

Name: dds_phase_gen

Overview:
- Phase-accumulator front end for the DDS wave path.
- Sits between the clock/frequency-select stage and the sine lookup table and DAC colour channels.
- Produces an 8-bit LUT address for the sine table, plus registered sawtooth, square and triangle samples.
- Frequency is set by a tuning word (FTW) loaded over a valid/ready handshake. An optional linear sweep FSM steps the FTW once per phase wrap.

Parameters:
- ACC_W, 32: phase accumulator width.
- OUT_W, 8: sample/LUT address width; uses the top OUT_W accumulator bits.
- FTW_RST, 32'h0000_0100: FTW value loaded at reset.

Ports:
- clk_in  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- run_en  in  1  level; 1 = accumulate, 0 = hold/idle
- ftw_in  in  ACC_W  tuning word to load
- ftw_valid  in  1  ftw_in valid
- ftw_ready  out  1  block can accept ftw_in
- sweep_start  in  1  single-cycle pulse; begins a sweep
- sweep_step  in  ACC_W  FTW increment applied per wrap
- sweep_limit  in  ACC_W  final FTW of the sweep
- sweep_done  out  1  single-cycle pulse when a sweep ends
- lut_addr  out  OUT_W  sine LUT address
- saw_out  out  OUT_W  sawtooth sample
- sq_out  out  OUT_W  square sample
- tri_out  out  OUT_W  triangle sample
- wrap  out  1  single-cycle pulse on accumulator carry-out
- state_out  out  2  current FSM state: 0 IDLE, 1 RUN, 2 SWEEP

Behaviour:
- Reset (rst=1 at an edge; overrides everything):
  - acc=0, ftw_cur=FTW_RST, state=IDLE.
  - All sample outputs 0; wrap=0, sweep_done=0.
  - ftw_ready=1 the cycle after reset.
  - Reset mid-sweep aborts the sweep with no sweep_done.
- FSM transitions:
  - IDLE -> RUN when run_en=1.
  - RUN -> SWEEP on sweep_start=1 with run_en=1.
  - SWEEP -> RUN when the sweep completes.
  - Any state -> IDLE when run_en=0; an active sweep is aborted, no sweep_done.
  - sweep_start while in IDLE or SWEEP is ignored.
- Accumulator:
  - In RUN/SWEEP: acc <= acc + ftw_cur, modulo 2^ACC_W.
  - In IDLE: acc holds and outputs hold their last values.
  - wrap=1 on the cycle after an update that produces a carry-out.
- Outputs are registered from the post-update acc, so there is 1 cycle of latency from the acc update. Let P = acc[ACC_W-1 -: OUT_W]:
  - lut_addr = P.
  - saw_out = P.
  - sq_out = all-ones if acc MSB=1, else 0.
  - tri_out = the next OUT_W bits below the MSB, bitwise inverted when the MSB=1. This gives a rising then falling ramp, peak 8'hFF at half phase.
- FTW handshake:
  - ftw_ready = 1 in IDLE and RUN, 0 in SWEEP and during reset.
  - Transfer occurs when ftw_valid && ftw_ready at an edge.
  - ftw_cur takes ftw_in at that edge; the first accumulation using the new word is the next edge. Loading is phase-continuous (acc is not cleared).
  - ftw_valid while ftw_ready=0: the word is not taken. The source must hold it until ready.
- Sweep:
  - If sweep_start and an FTW transfer occur in the same cycle, the sweep starts from the newly loaded word.
  - If sweep_limit <= starting ftw_cur: the state stays RUN, ftw_cur is unchanged, and sweep_done pulses the next cycle.
  - sweep_step and sweep_limit are captured at sweep_start; later input changes are ignored.
  - In SWEEP, on each cycle where wrap is generated:
    - If ftw_cur + step >= limit, or the sum overflows ACC_W bits: ftw_cur <= limit, state -> RUN, sweep_done pulses one cycle later.
    - Otherwise ftw_cur <= ftw_cur + step.
  - sweep_step=0 with limit > ftw_cur: the sweep never ends until run_en=0. This is legal.
- ftw_cur=0 in RUN: acc holds its value and wrap never fires. This is legal.

Test Plan:
- Reset/outputs: after rst, run_en=1, ACC_W=32 with FTW_RST=32'h0100_0000 -> lut_addr counts 0,1,2,…,255,0 (one step per cycle, first nonzero value 2 edges after run_en); wrap pulses every 256 cycles; sq_out switches 00->FF at lut_addr 128; tri_out peaks at FF.
- Handshake: load FTW 32'h0200_0000 in RUN -> ftw_ready=1, lut_addr steps by 2 from the next update, with no phase discontinuity. Assert ftw_valid in SWEEP -> not accepted until the return to RUN.
- Sweep: ftw 32'h0100_0000, step 32'h0100_0000, limit 32'h0400_0000 -> ftw_cur goes 1,2,3,4 (x2^24) at successive wraps; sweep_done pulses once; state returns to RUN.
- Sweep overflow/clamp: ftw 32'hF000_0000, step 32'h2000_0000, limit 32'hFFFF_0000 -> ftw_cur clamps to FFFF_0000 at the first wrap; sweep_done pulses.
- Abort: drop run_en mid-sweep -> state IDLE, acc and outputs frozen, no sweep_done. Raise run_en again -> RUN (not SWEEP).
- Degenerate: sweep_start with limit 0x10 below ftw_cur -> sweep_done the next cycle, ftw unchanged. Assert rst mid-run -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/dds_phase_gen.sv
// Phase-accumulator front end for the DDS wave path: FTW load handshake, linear
// sweep FSM, and registered LUT-address / sawtooth / square / triangle samples.
module dds_phase_gen #(
    parameter int unsigned         ACC_W   = 32,
    parameter int unsigned         OUT_W   = 8,
    parameter logic [ACC_W-1:0]    FTW_RST = 32'h0000_0100
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run_en,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_valid,
    output logic             ftw_ready,
    input  logic             sweep_start,
    input  logic [ACC_W-1:0] sweep_step,
    input  logic [ACC_W-1:0] sweep_limit,
    output logic             sweep_done,
    output logic [OUT_W-1:0] lut_addr,
    output logic [OUT_W-1:0] saw_out,
    output logic [OUT_W-1:0] sq_out,
    output logic [OUT_W-1:0] tri_out,
    output logic             wrap,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StSweep = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    logic [ACC_W-1:0] step_q, step_d;
    logic [ACC_W-1:0] limit_q, limit_d;
    logic             wrap_q, done_q, done_d;
    logic [OUT_W-1:0] phase_q, phase_d;
    logic [OUT_W-1:0] sq_q, sq_d;
    logic [OUT_W-1:0] tri_q, tri_d;

    logic             active;
    logic             carry;
    logic             ftw_xfer;
    logic [ACC_W-1:0] ftw_load;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W:0]   step_sum;
    logic             sweep_end;
    logic [OUT_W-1:0] tri_bits;

    always_comb begin
        ftw_ready = !rst && (state_q != StSweep);
        ftw_xfer  = ftw_valid && ftw_ready;
        ftw_load  = ftw_xfer ? ftw_in : ftw_q;

        active  = (state_q != StIdle);
        acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};
        acc_d   = active ? acc_sum[ACC_W-1:0] : acc_q;
        carry   = active && acc_sum[ACC_W];

        // Carry out of the step add counts as reaching the limit.
        step_sum  = {1'b0, ftw_q} + {1'b0, step_q};
        sweep_end = step_sum[ACC_W] || (step_sum[ACC_W-1:0] >= limit_q);
    end

    always_comb begin
        state_d = state_q;
        ftw_d   = ftw_load;
        step_d  = step_q;
        limit_d = limit_q;
        done_d  = 1'b0;
        if (!run_en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (sweep_start) begin
                        if (sweep_limit <= ftw_load) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StSweep;
                            step_d  = sweep_step;
                            limit_d = sweep_limit;
                        end
                    end
                end
                StSweep: begin
                    if (carry) begin
                        if (sweep_end) begin
                            ftw_d   = limit_q;
                            state_d = StRun;
                            done_d  = 1'b1;
                        end else begin
                            ftw_d = step_sum[ACC_W-1:0];
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Samples are formed from the post-update accumulator value.
    always_comb begin
        phase_d  = acc_d[ACC_W-1 -: OUT_W];
        sq_d     = {OUT_W{acc_d[ACC_W-1]}};
        tri_bits = acc_d[ACC_W-2 -: OUT_W];
        tri_d    = acc_d[ACC_W-1] ? ~tri_bits : tri_bits;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ftw_q   <= FTW_RST;
            step_q  <= '0;
            limit_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= '0;
            sq_q    <= '0;
            tri_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            step_q  <= step_d;
            limit_q <= limit_d;
            wrap_q  <= carry;
            done_q  <= done_d;
            phase_q <= phase_d;
            sq_q    <= sq_d;
            tri_q   <= tri_d;
        end
    end

    assign lut_addr   = phase_q;
    assign saw_out    = phase_q;
    assign sq_out     = sq_q;
    assign tri_out    = tri_q;
    assign wrap       = wrap_q;
    assign sweep_done = done_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: cycle model feeding a scoreboard, a constant vector
// table for the start-up sequence, and directed ramp / sweep / abort sequences.
module tb_dds_phase_gen;

    localparam int unsigned  ACC_W   = 32;
    localparam int unsigned  OUT_W   = 8;
    localparam logic [31:0]  FTW_RST = 32'h0100_0000;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        run_en = 1'b0;
    logic [31:0] ftw_in = '0;
    logic        ftw_valid = 1'b0;
    logic        ftw_ready;
    logic        sweep_start = 1'b0;
    logic [31:0] sweep_step = '0;
    logic [31:0] sweep_limit = '0;
    logic        sweep_done;
    logic [7:0]  lut_addr, saw_out, sq_out, tri_out;
    logic        wrap;
    logic [1:0]  state_out;

    always #5 clk_in = ~clk_in;

    dds_phase_gen #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .FTW_RST (FTW_RST)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .run_en      (run_en),
        .ftw_in      (ftw_in),
        .ftw_valid   (ftw_valid),
        .ftw_ready   (ftw_ready),
        .sweep_start (sweep_start),
        .sweep_step  (sweep_step),
        .sweep_limit (sweep_limit),
        .sweep_done  (sweep_done),
        .lut_addr    (lut_addr),
        .saw_out     (saw_out),
        .sq_out      (sq_out),
        .tri_out     (tri_out),
        .wrap        (wrap),
        .state_out   (state_out)
    );

    typedef struct packed {
        logic [7:0] lut;
        logic [7:0] saw;
        logic [7:0] sq;
        logic [7:0] tri_s;
        logic       wrp;
        logic       done;
        logic       ready;
        logic [1:0] state;
    } obs_t;

    typedef struct {
        logic        r;
        logic        re;
        logic        fv;
        logic [31:0] fi;
        logic        ss;
        logic [31:0] lim;
        logic [7:0]  lut;
        logic [1:0]  st;
        logic        dn;
        logic        rdy;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    obs_t q_exp[$];
    vec_t vecs[16];

    logic [31:0] m_acc = '0, m_ftw = '0, m_step = '0, m_limit = '0;
    logic [1:0]  m_state = '0;
    logic        m_wrap = 1'b0, m_done = 1'b0;

    function automatic vec_t mk(logic r, logic re, logic fv, logic [31:0] fi, logic ss,
                                logic [31:0] lim, logic [7:0] lut, logic [1:0] st,
                                logic dn, logic rdy);
        vec_t v;
        v.r = r; v.re = re; v.fv = fv; v.fi = fi; v.ss = ss; v.lim = lim;
        v.lut = lut; v.st = st; v.dn = dn; v.rdy = rdy;
        return v;
    endfunction

    task automatic model_step();
        logic [32:0] s;
        logic [32:0] sw;
        logic [31:0] nf;
        if (rst) begin
            m_acc = '0; m_ftw = FTW_RST; m_state = 2'd0; m_wrap = 1'b0; m_done = 1'b0;
        end else begin
            nf = (ftw_valid && m_state != 2'd2) ? ftw_in : m_ftw;
            m_wrap = 1'b0;
            m_done = 1'b0;
            s = {1'b0, m_acc} + {1'b0, m_ftw};
            if (m_state != 2'd0) begin
                m_acc  = s[31:0];
                m_wrap = s[32];
            end
            if (!run_en) begin
                m_state = 2'd0;
            end else if (m_state == 2'd0) begin
                m_state = 2'd1;
            end else if (m_state == 2'd1) begin
                if (sweep_start) begin
                    if (sweep_limit <= nf) begin
                        m_done = 1'b1;
                    end else begin
                        m_state = 2'd2;
                        m_step  = sweep_step;
                        m_limit = sweep_limit;
                    end
                end
            end else if (s[32]) begin
                sw = {1'b0, m_ftw} + {1'b0, m_step};
                if (sw[32] || sw[31:0] >= m_limit) begin
                    nf = m_limit; m_state = 2'd1; m_done = 1'b1;
                end else begin
                    nf = sw[31:0];
                end
            end
            m_ftw = nf;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.lut   = m_acc[31:24];
        o.saw   = m_acc[31:24];
        o.sq    = {8{m_acc[31]}};
        o.tri_s = m_acc[31] ? ~m_acc[30:23] : m_acc[30:23];
        o.wrp   = m_wrap;
        o.done  = m_done;
        o.ready = !rst && (m_state != 2'd2);
        o.state = m_state;
        return o;
    endfunction

    task automatic check_sb();
        obs_t e, a;
        e = q_exp.pop_front();
        a = '{lut: lut_addr, saw: saw_out, sq: sq_out, tri_s: tri_out, wrp: wrap,
              done: sweep_done, ready: ftw_ready, state: state_out};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t actual lut=%h saw=%h sq=%h tri=%h wrap=%b done=%b rdy=%b st=%0d required lut=%h saw=%h sq=%h tri=%h wrap=%b done=%b rdy=%b st=%0d",
                     $time, a.lut, a.saw, a.sq, a.tri_s, a.wrp, a.done, a.ready, a.state,
                     e.lut, e.saw, e.sq, e.tri_s, e.wrp, e.done, e.ready, e.state);
        end
    endtask

    task automatic dchk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        q_exp.push_back(model_obs());
        #1;
        check_sb();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          wraps;
        int          dones;
        int          got;
        logic [7:0]  prev, d, frozen;
        logic [7:0]  diffs[$];
        logic [7:0]  sweep_exp[5];

        //                r  re fv  ftw_in        ss limit         lut    st  dn rdy
        vecs[0]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         8'd0,  0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         8'd0,  0, 0, 1);
        vecs[2]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         8'd0,  1, 0, 1);
        vecs[3]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         8'd1,  1, 0, 1);
        vecs[4]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         8'd2,  1, 0, 1);
        vecs[5]  = mk(0, 1, 1, 32'h0200_0000, 0, 32'h0,         8'd3,  1, 0, 1);
        vecs[6]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         8'd5,  1, 0, 1);
        vecs[7]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         8'd7,  1, 0, 1);
        vecs[8]  = mk(0, 1, 0, 32'h0,         1, 32'h01FF_FFF0, 8'd9,  1, 1, 1);
        vecs[9]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         8'd11, 1, 0, 1);
        vecs[10] = mk(0, 0, 0, 32'h0,         0, 32'h0,         8'd13, 0, 0, 1);
        vecs[11] = mk(0, 0, 0, 32'h0,         0, 32'h0,         8'd13, 0, 0, 1);
        vecs[12] = mk(0, 1, 1, 32'h0100_0000, 0, 32'h0,         8'd13, 1, 0, 1);
        vecs[13] = mk(0, 1, 0, 32'h0,         0, 32'h0,         8'd14, 1, 0, 1);
        vecs[14] = mk(1, 1, 0, 32'h0,         0, 32'h0,         8'd0,  0, 0, 0);
        vecs[15] = mk(0, 0, 0, 32'h0,         0, 32'h0,         8'd0,  0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].r; run_en = vecs[i].re; ftw_valid = vecs[i].fv;
            ftw_in = vecs[i].fi; sweep_start = vecs[i].ss; sweep_limit = vecs[i].lim;
            sweep_step = '0;
            cycle();
            dchk($sformatf("vec%0d_lut", i), 32'(lut_addr), 32'(vecs[i].lut));
            dchk($sformatf("vec%0d_state", i), 32'(state_out), 32'(vecs[i].st));
            dchk($sformatf("vec%0d_done", i), 32'(sweep_done), 32'(vecs[i].dn));
            dchk($sformatf("vec%0d_ready", i), 32'(ftw_ready), 32'(vecs[i].rdy));
            dchk($sformatf("vec%0d_wrap", i), 32'(wrap), 0);
        end
        ftw_valid = 1'b0; sweep_start = 1'b0;

        // Ramp from reset with FTW = 2^24: one LUT step per cycle.
        run_en = 1'b1;
        cycle();
        dchk("ramp_state", 32'(state_out), 1);
        dchk("ramp_lut0", 32'(lut_addr), 0);
        cycle();
        dchk("ramp_first", 32'(lut_addr), 1);
        wraps = 0;
        for (int k = 3; k <= 520; k++) begin
            cycle();
            if (wrap) wraps++;
            if (k == 128) begin
                dchk("ramp_sq_low", 32'(sq_out), 0);
                dchk("ramp_tri_fe", 32'(tri_out), 32'h0FE);
            end
            if (k == 129) begin
                dchk("ramp_lut_half", 32'(lut_addr), 128);
                dchk("ramp_sq_high", 32'(sq_out), 32'h0FF);
                dchk("ramp_tri_peak", 32'(tri_out), 32'h0FF);
            end
            if (k == 256) dchk("ramp_nowrap", 32'(wrap), 0);
            if (k == 257) begin
                dchk("ramp_wrap_lut", 32'(lut_addr), 0);
                dchk("ramp_wrap", 32'(wrap), 1);
            end
        end
        dchk("ramp_wraps", 32'(wraps), 2);
        dchk("ramp_end", 32'(lut_addr), 7);

        // Sweep 1..4 x 2^24 loaded with the start, while a blocked FTW waits.
        sweep_exp[0] = 8'd1; sweep_exp[1] = 8'd2; sweep_exp[2] = 8'd3;
        sweep_exp[3] = 8'd4; sweep_exp[4] = 8'd3;
        ftw_valid = 1'b1; ftw_in = 32'h0100_0000; sweep_start = 1'b1;
        sweep_step = 32'h0100_0000; sweep_limit = 32'h0400_0000;
        prev = lut_addr;
        cycle();
        dchk("sweep_state", 32'(state_out), 2);
        dchk("sweep_ready", 32'(ftw_ready), 0);
        d = lut_addr - prev; prev = lut_addr; diffs.push_back(d);
        sweep_start = 1'b0; ftw_in = 32'h0300_0000; sweep_step = '0; sweep_limit = '0;
        got = 0; dones = 0;
        for (int i = 0; i < 3000 && got == 0; i++) begin
            cycle();
            d = lut_addr - prev; prev = lut_addr;
            if (diffs[$] != d) diffs.push_back(d);
            if (sweep_done) begin
                got = 1; dones++;
            end
        end
        dchk("sweep_done_seen", 32'(got), 1);
        dchk("sweep_back_run", 32'(state_out), 1);
        dchk("sweep_ready_back", 32'(ftw_ready), 1);
        for (int i = 0; i < 2; i++) begin
            cycle();
            d = lut_addr - prev; prev = lut_addr;
            if (diffs[$] != d) diffs.push_back(d);
            if (sweep_done) dones++;
        end
        ftw_valid = 1'b0;
        cycle();
        if (sweep_done) dones++;
        dchk("sweep_done_count", 32'(dones), 1);
        dchk("sweep_diff_count", 32'(diffs.size()), 5);
        for (int i = 0; i < 5 && i < diffs.size(); i++)
            dchk($sformatf("sweep_diff%0d", i), 32'(diffs[i]), 32'(sweep_exp[i]));

        // Overflowing step clamps to the limit on the first wrap.
        ftw_valid = 1'b1; ftw_in = 32'hF000_0000; sweep_start = 1'b1;
        sweep_step = 32'h2000_0000; sweep_limit = 32'hFFFF_0000;
        cycle();
        dchk("clamp_state", 32'(state_out), 2);
        ftw_valid = 1'b0; sweep_start = 1'b0; sweep_step = '0; sweep_limit = '0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            cycle();
            if (sweep_done) got = 1;
        end
        dchk("clamp_done_seen", 32'(got), 1);
        dchk("clamp_back_run", 32'(state_out), 1);
        dones = 0;
        repeat (5) begin
            cycle();
            if (sweep_done) dones++;
        end
        dchk("clamp_single_done", 32'(dones), 0);

        // Abort a long sweep by dropping run_en.
        ftw_valid = 1'b1; ftw_in = 32'h0100_0000; sweep_start = 1'b1;
        sweep_step = 32'h0100_0000; sweep_limit = 32'h8000_0000;
        cycle();
        dchk("abort_sweep_state", 32'(state_out), 2);
        ftw_valid = 1'b0; sweep_start = 1'b0;
        dones = 0;
        repeat (30) begin
            cycle();
            if (sweep_done) dones++;
        end
        dchk("abort_still_sweep", 32'(state_out), 2);
        run_en = 1'b0;
        cycle();
        if (sweep_done) dones++;
        dchk("abort_idle", 32'(state_out), 0);
        frozen = m_acc[31:24];
        repeat (8) begin
            cycle();
            if (sweep_done) dones++;
        end
        dchk("abort_frozen", 32'(lut_addr), 32'(frozen));
        dchk("abort_no_done", 32'(dones), 0);
        run_en = 1'b1;
        cycle();
        dchk("abort_rerun", 32'(state_out), 1);
        cycle();
        dchk("abort_not_sweep", 32'(state_out), 1);

        // Zero FTW: phase holds, no wraps.
        ftw_valid = 1'b1; ftw_in = '0;
        cycle();
        ftw_valid = 1'b0;
        cycle();
        frozen = m_acc[31:24];
        wraps = 0;
        repeat (300) begin
            cycle();
            if (wrap) wraps++;
        end
        dchk("zero_ftw_wraps", 32'(wraps), 0);
        dchk("zero_ftw_hold", 32'(lut_addr), 32'(frozen));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
